// File: rtl/ps2_kbd_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_writer_if
// Purpose  : Memory B-port (I/O) bus between the keyboard writer and memory.
// Revision : 1.0
// ============================================================================
interface ps2_kbd_writer_if;
    logic [31:0] io_addr;
    logic        io_wren;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;

    modport master (
        output io_addr,
        output io_wren,
        output io_wdata,
        input  io_rdata
    );

    modport slave (
        input  io_addr,
        input  io_wren,
        input  io_wdata,
        output io_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ps2_kbd_writer.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_writer
// Purpose  : PS/2 keyboard deframer that appends good scancodes to a ring
//            buffer in data memory and publishes the head index.
// Revision : 1.0
// ============================================================================
module ps2_kbd_writer #(
    parameter logic [31:0] BUF_BASE  = 32'h0000_0100,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] HEAD_ADDR = 32'h0000_00F0,
    parameter logic [31:0] TAIL_ADDR = 32'h0000_00F4,
    parameter int          TIMEOUT   = 50000
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              ps2_clk,
    input  wire              ps2_data,
    ps2_kbd_writer_if.master io,
    output logic [7:0]       err_cnt,
    output logic [7:0]       drop_cnt,
    output logic             busy
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_TAIL   = 3'd1,
        S_WAIT_TAIL = 3'd2,
        S_CHECK     = 3'd3,
        S_WR_DATA   = 3'd4,
        S_WR_HEAD   = 3'd5
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_clk_sync;
    logic [1:0]          r_dat_sync;
    logic [3:0]          r_bit_cnt;
    logic [9:0]          r_shift;
    logic [c_TO_W-1:0]   r_idle_cnt;
    logic [7:0]          r_pending;
    logic                r_pending_valid;
    logic [c_PTR_W-1:0]  r_head;

    logic                w_fall;
    logic                w_bit;
    logic [10:0]         w_frame;
    logic                w_frame_done;
    logic                w_good;
    logic                w_take;
    logic                w_frame_drop;
    logic                w_full_drop;
    logic [c_PTR_W-1:0]  w_head_inc;
    logic [c_PTR_W-1:0]  w_tail;
    logic [8:0]          w_drop_sum;
    logic [31:0]         w_addr_nxt;
    logic [31:0]         w_wdata_nxt;
    logic                w_wren_nxt;
    logic                w_unused_rdata;

    // Bus idles high, so the synchronisers come out of reset at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
        end
    end

    assign w_fall       = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_bit        = r_dat_sync[1];
    assign w_frame      = {w_bit, r_shift};
    assign w_frame_done = w_fall && (r_bit_cnt == 4'd10);
    assign w_good       = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_idle_cnt <= '0;
        end else if (w_fall) begin
            r_idle_cnt <= '0;
            r_shift    <= {w_bit, r_shift[9:1]};
            r_bit_cnt  <= (r_bit_cnt == 4'd10) ? 4'd0 : r_bit_cnt + 4'd1;
        end else if (r_bit_cnt != 4'd0) begin
            if (r_idle_cnt == c_TO_LAST) begin
                r_bit_cnt  <= '0;
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
            end
        end
    end

    // Pointer width equals log2(DEPTH), so the increment wraps on its own.
    assign w_head_inc     = r_head + c_PTR_W'(1);
    assign w_tail         = io.io_rdata[c_PTR_W-1:0];
    assign w_unused_rdata = ^io.io_rdata;
    assign w_full_drop    = (r_state == S_CHECK) && (w_head_inc == w_tail);
    // The slot frees up in WR_DATA, so a byte arriving then is still taken.
    assign w_take         = w_frame_done & w_good & (~r_pending_valid | (r_state == S_WR_DATA));
    assign w_frame_drop   = w_frame_done & w_good & ~w_take;
    assign w_drop_sum     = {1'b0, drop_cnt} + {8'd0, w_frame_drop} + {8'd0, w_full_drop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            err_cnt         <= '0;
            drop_cnt        <= '0;
        end else begin
            if (w_take) begin
                r_pending       <= w_frame[8:1];
                r_pending_valid <= 1'b1;
            end else if ((r_state == S_WR_DATA) || w_full_drop) begin
                r_pending_valid <= 1'b0;
            end
            if (w_frame_done && !w_good && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
            drop_cnt <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    // Outputs are decoded from the next state so the registered bus lines up
    // with the state that owns it.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
        w_wren_nxt  = 1'b0;
        case (r_state)
            S_IDLE:      if (r_pending_valid) w_state_nxt = S_RD_TAIL;
            S_RD_TAIL:   w_state_nxt = S_WAIT_TAIL;
            S_WAIT_TAIL: w_state_nxt = S_CHECK;
            S_CHECK:     w_state_nxt = w_full_drop ? S_IDLE : S_WR_DATA;
            S_WR_DATA:   w_state_nxt = S_WR_HEAD;
            S_WR_HEAD:   w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
        case (w_state_nxt)
            S_RD_TAIL, S_WAIT_TAIL, S_CHECK: w_addr_nxt = TAIL_ADDR;
            S_WR_DATA: begin
                w_addr_nxt  = BUF_BASE + 32'(r_head);
                w_wdata_nxt = {24'h0, r_pending};
                w_wren_nxt  = 1'b1;
            end
            S_WR_HEAD: begin
                w_addr_nxt  = HEAD_ADDR;
                w_wdata_nxt = 32'(w_head_inc);
                w_wren_nxt  = 1'b1;
            end
            default: w_addr_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            io.io_addr  <= '0;
            io.io_wren  <= 1'b0;
            io.io_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            io.io_addr  <= w_addr_nxt;
            io.io_wren  <= w_wren_nxt;
            io.io_wdata <= w_wdata_nxt;
            if (r_state == S_WR_DATA)
                r_head <= w_head_inc;
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_writer
// Purpose  : Self-checking bench for ps2_kbd_writer with a ring-buffer model.
// Revision : 1.0
// ============================================================================
module tb_ps2_kbd_writer;
    localparam logic [31:0] c_BUF_BASE  = 32'h0000_0100;
    localparam logic [31:0] c_HEAD_ADDR = 32'h0000_00F0;
    localparam logic [31:0] c_TAIL_ADDR = 32'h0000_00F4;
    localparam int          c_DEPTH     = 16;
    localparam int          c_TIMEOUT   = 200;
    localparam int          c_HALF      = 4;
    localparam int          c_GAP       = 16;

    typedef struct {
        logic [7:0]  d;
        bit          bs;
        bit          bp;
        bit          bst;
        logic [31:0] tail;
        int          nwr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] head;
        int          err;
        int          drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [7:0]  err_cnt;
    logic [7:0]  drop_cnt;
    logic        busy;
    logic [31:0] tail_val = 32'd0;

    ps2_kbd_writer_if bus();

    ps2_kbd_writer #(
        .BUF_BASE  (c_BUF_BASE),
        .DEPTH     (c_DEPTH),
        .HEAD_ADDR (c_HEAD_ADDR),
        .TAIL_ADDR (c_TAIL_ADDR),
        .TIMEOUT   (c_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .io       (bus),
        .err_cnt  (err_cnt),
        .drop_cnt (drop_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Registered single-location memory: only the tail word reads back.
    always @(posedge clk)
        bus.io_rdata <= (bus.io_addr == c_TAIL_ADDR) ? tail_val : 32'h0;

    logic [63:0] obs[$];
    int          runs[$];
    int          run_len = 0;

    always @(negedge clk) begin
        if (bus.io_wren === 1'b1) begin
            obs.push_back({bus.io_addr, bus.io_wdata});
            run_len <= run_len + 1;
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len <= 0;
        end
    end

    int          n_chk = 0;
    int          n_err = 0;
    int          m_head, m_err, m_drop, obs_rd, runs_rd;
    logic [63:0] m_exp[$];
    vec_t        vecs[7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bs, input bit bp, input bit bst);
        return {~bst, (~^d) ^ bp, d, bs};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = f[i];
            repeat (c_HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (c_HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bs, input bit bp, input bit bst);
        send_bits(mk_frame(d, bs, bp, bst), 11);
        repeat (c_GAP) @(negedge clk);
    endtask

    task automatic model_reset();
        m_head  = 0;
        m_err   = 0;
        m_drop  = 0;
        m_exp.delete();
        obs_rd  = obs.size();
        runs_rd = runs.size();
    endtask

    // Ring buffer keeping one slot empty; counters saturate at 255.
    task automatic model_frame(input logic [7:0] d, input bit good);
        if (!good) begin
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end else if (((m_head + 1) % c_DEPTH) == (tail_val % c_DEPTH)) begin
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end else begin
            m_exp.push_back({c_BUF_BASE + m_head, 24'h0, d});
            m_head = (m_head + 1) % c_DEPTH;
            m_exp.push_back({c_HEAD_ADDR, 32'(m_head)});
        end
    endtask

    task automatic check_model(input string name);
        int n_obs;
        n_obs = obs.size() - obs_rd;
        chk({name, " write count"}, 32'(n_obs), 32'(m_exp.size()));
        for (int i = 0; i < m_exp.size() && i < n_obs; i++) begin
            chk({name, " addr"}, obs[obs_rd + i][63:32], m_exp[i][63:32]);
            chk({name, " data"}, obs[obs_rd + i][31:0], m_exp[i][31:0]);
        end
        obs_rd = obs.size();
        m_exp.delete();
        while (runs_rd < runs.size()) begin
            chk({name, " wren run length"}, 32'(runs[runs_rd]), 32'd2);
            runs_rd++;
        end
        chk({name, " err_cnt"}, {24'h0, err_cnt}, 32'(m_err));
        chk({name, " drop_cnt"}, {24'h0, drop_cnt}, 32'(m_drop));
    endtask

    task automatic do_frame(input string name, input logic [7:0] d, input bit bs, input bit bp, input bit bst);
        send_frame(d, bs, bp, bst);
        model_frame(d, !(bs | bp | bst));
        check_model(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();
    endtask

    initial begin
        int k;
        int n_obs;
        vecs[0] = '{8'h1C, 1'b0, 1'b0, 1'b0, 32'd0, 1, 32'h100, 32'h1C, 32'd1, 0, 0};
        vecs[1] = '{8'h1C, 1'b0, 1'b1, 1'b0, 32'd0, 0, 32'h0,   32'h0,  32'd0, 1, 0};
        vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b1, 32'd0, 0, 32'h0,   32'h0,  32'd0, 2, 0};
        vecs[3] = '{8'hA5, 1'b0, 1'b0, 1'b0, 32'd0, 1, 32'h101, 32'hA5, 32'd2, 2, 0};
        vecs[4] = '{8'h3F, 1'b0, 1'b0, 1'b0, 32'd3, 0, 32'h0,   32'h0,  32'd0, 2, 1};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 32'd3, 0, 32'h0,   32'h0,  32'd0, 3, 1};
        vecs[6] = '{8'h7E, 1'b0, 1'b0, 1'b0, 32'd0, 1, 32'h102, 32'h7E, 32'd3, 3, 1};

        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset io_addr", bus.io_addr, 32'h0);
        chk("reset io_wren", {31'h0, bus.io_wren}, 32'h0);
        chk("reset io_wdata", bus.io_wdata, 32'h0);
        chk("reset err_cnt", {24'h0, err_cnt}, 32'h0);
        chk("reset drop_cnt", {24'h0, drop_cnt}, 32'h0);
        chk("reset busy", {31'h0, busy}, 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();

        for (int v = 0; v < 7; v++) begin
            tail_val = vecs[v].tail;
            send_frame(vecs[v].d, vecs[v].bs, vecs[v].bp, vecs[v].bst);
            model_frame(vecs[v].d, !(vecs[v].bs | vecs[v].bp | vecs[v].bst));
            n_obs = obs.size() - obs_rd;
            chk($sformatf("vec%0d write count", v), 32'(n_obs), 32'(2 * vecs[v].nwr));
            if (vecs[v].nwr != 0 && n_obs >= 2) begin
                chk($sformatf("vec%0d data addr", v), obs[obs_rd][63:32], vecs[v].addr);
                chk($sformatf("vec%0d data", v), obs[obs_rd][31:0], vecs[v].data);
                chk($sformatf("vec%0d head addr", v), obs[obs_rd + 1][63:32], c_HEAD_ADDR);
                chk($sformatf("vec%0d head", v), obs[obs_rd + 1][31:0], vecs[v].head);
            end
            chk($sformatf("vec%0d err_cnt", v), {24'h0, err_cnt}, 32'(vecs[v].err));
            chk($sformatf("vec%0d drop_cnt", v), {24'h0, drop_cnt}, 32'(vecs[v].drop));
            obs_rd = obs.size();
            runs_rd = runs.size();
            m_exp.delete();
        end

        // Reset in the middle of a frame.
        send_bits(mk_frame(8'h12, 1'b0, 1'b0, 1'b0), 5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midframe rst io_wren", {31'h0, bus.io_wren}, 32'h0);
        chk("midframe rst err_cnt", {24'h0, err_cnt}, 32'h0);
        chk("midframe rst drop_cnt", {24'h0, drop_cnt}, 32'h0);
        chk("midframe rst busy", {31'h0, busy}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();

        // Reset during WR_DATA must drop io_wren without waiting for a clock.
        tail_val = 32'd0;
        send_bits(mk_frame(8'h33, 1'b0, 1'b0, 1'b0), 11);
        k = 0;
        while (bus.io_wren !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("wait for WR_DATA", {31'h0, bus.io_wren}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("wr_data rst io_wren", {31'h0, bus.io_wren}, 32'h0);
        chk("wr_data rst io_addr", bus.io_addr, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();
        do_frame("after reset", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Partial frame abandoned by the idle timeout.
        send_bits(mk_frame(8'h77, 1'b0, 1'b0, 1'b0), 6);
        repeat (c_TIMEOUT + 20) @(negedge clk);
        do_frame("after timeout", 8'hF0, 1'b0, 1'b0, 1'b0);

        // Fill the ring with tail at 0, then free space and wrap.
        do_reset();
        tail_val = 32'd0;
        for (int i = 0; i < 16; i++)
            do_frame($sformatf("fill%0d", i), 8'($urandom), 1'b0, 1'b0, 1'b0);
        chk("fill drop_cnt", {24'h0, drop_cnt}, 32'd1);
        chk("fill last head", obs[obs.size() - 1], {c_HEAD_ADDR, 32'd15});
        tail_val = 32'd5;
        do_frame("wrap", 8'hC3, 1'b0, 1'b0, 1'b0);
        chk("wrap data addr", obs[obs.size() - 2][63:32], c_BUF_BASE + 32'd15);
        chk("wrap head", obs[obs.size() - 1][31:0], 32'd0);

        for (int i = 0; i < 24; i++) begin
            int r;
            r = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0)
                tail_val = 32'($urandom_range(0, c_DEPTH - 1));
            do_frame($sformatf("rand%0d", i), 8'($urandom), r == 0, r == 1, r == 2);
        end

        // Hold the ring full long enough to saturate drop_cnt.
        tail_val = 32'((m_head + 1) % c_DEPTH);
        for (int i = 0; i < 258; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            send_frame(d, 1'b0, 1'b0, 1'b0);
            model_frame(d, 1'b1);
        end
        check_model("saturate");
        chk("drop_cnt saturated", {24'h0, drop_cnt}, 32'hFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
